// File: rtl/ulpb_tx_sched.sv
// ulpb_tx_sched: round-robin transmit scheduler for a single bus node.
// Arbitrates local requesters onto one node transmitter. Lost bus
// arbitration is retried after a fixed idle gap, up to a retry limit.
// Each message ends in exactly one ACK or FAIL pulse.
module ulpb_tx_sched #(
  parameter int NUM_REQ     = 4,
  parameter int ADDR_WIDTH  = 8,
  parameter int DATA_WIDTH  = 32,
  parameter int MAX_RETRY   = 3,
  parameter int BACKOFF_CYC = 4
) (
  input  logic                          i_clk,
  input  logic                          i_rst_n,
  input  logic [NUM_REQ-1:0]            i_req,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] i_req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] i_req_data,
  output logic [NUM_REQ-1:0]            o_grant,
  output logic [NUM_REQ-1:0]            o_ack,
  output logic [NUM_REQ-1:0]            o_fail,
  output logic                          o_tx_req,
  output logic [ADDR_WIDTH-1:0]         o_tx_addr,
  output logic [DATA_WIDTH-1:0]         o_tx_data,
  input  logic                          i_tx_done,
  input  logic                          i_tx_acked,
  input  logic                          i_tx_lost
);

  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
  localparam int CW = $clog2(BACKOFF_CYC + 1);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_TX       = 2'd1,
    S_BACKOFF  = 2'd2,
    S_COOLDOWN = 2'd3
  } state_t;

  state_t                r_state, w_state_nxt;
  logic [NUM_REQ-1:0]    r_grant, w_grant_nxt;
  logic [NUM_REQ-1:0]    r_ack, w_ack_nxt;
  logic [NUM_REQ-1:0]    r_fail, w_fail_nxt;
  logic                  r_tx_req, w_tx_req_nxt;
  logic [ADDR_WIDTH-1:0] r_tx_addr, w_rr_addr;
  logic [DATA_WIDTH-1:0] r_tx_data, w_rr_data;
  logic [RW-1:0]         r_retry, w_retry_nxt;
  logic [CW-1:0]         r_cnt, w_cnt_nxt;
  logic [IW-1:0]         r_win, w_win_nxt;
  logic [IW-1:0]         r_last, w_last_nxt;
  logic [IW-1:0]         w_rr_win;
  logic [IW:0]           w_rr_idx;
  logic                  w_rr_hit;
  logic                  w_load;

  // Round-robin search: first active request after the previous winner, wrapping.
  always_comb begin
    w_rr_hit = 1'b0;
    w_rr_win = '0;
    w_rr_idx = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      w_rr_idx = {1'b0, r_last} + (IW+1)'(k);
      if (w_rr_idx >= (IW+1)'(NUM_REQ))
        w_rr_idx = w_rr_idx - (IW+1)'(NUM_REQ);
      if (!w_rr_hit && i_req[w_rr_idx[IW-1:0]]) begin
        w_rr_hit = 1'b1;
        w_rr_win = w_rr_idx[IW-1:0];
      end
    end
  end

  // Select the candidate winner's address/payload slice for latching.
  always_comb begin
    w_rr_addr = '0;
    w_rr_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_rr_win == IW'(i)) begin
        w_rr_addr = i_req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
        w_rr_data = i_req_data[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // Next-state and next-output decode; all outputs are registered.
  always_comb begin
    w_state_nxt  = r_state;
    w_grant_nxt  = r_grant;
    w_ack_nxt    = '0;
    w_fail_nxt   = '0;
    w_tx_req_nxt = r_tx_req;
    w_retry_nxt  = r_retry;
    w_cnt_nxt    = r_cnt;
    w_win_nxt    = r_win;
    w_last_nxt   = r_last;
    w_load       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_rr_hit) begin
          w_state_nxt  = S_TX;
          w_win_nxt    = w_rr_win;
          w_grant_nxt  = {{(NUM_REQ-1){1'b0}}, 1'b1} << w_rr_win;
          w_tx_req_nxt = 1'b1;
          w_retry_nxt  = '0;
          w_load       = 1'b1;
        end
      end
      S_TX: begin
        // A completion outranks a simultaneous arbitration loss.
        if (i_tx_done) begin
          w_ack_nxt    = i_tx_acked ? r_grant : '0;
          w_fail_nxt   = i_tx_acked ? '0 : r_grant;
          w_grant_nxt  = '0;
          w_tx_req_nxt = 1'b0;
          w_state_nxt  = S_COOLDOWN;
        end else if (i_tx_lost) begin
          w_tx_req_nxt = 1'b0;
          if (r_retry < RW'(MAX_RETRY)) begin
            w_retry_nxt = r_retry + RW'(1);
            w_cnt_nxt   = CW'(BACKOFF_CYC);
            w_state_nxt = S_BACKOFF;
          end else begin
            w_fail_nxt  = r_grant;
            w_grant_nxt = '0;
            w_state_nxt = S_COOLDOWN;
          end
        end
      end
      S_BACKOFF: begin
        // Counter holds BACKOFF_CYC on entry, so TX_REQ stays low that many cycles.
        if (r_cnt <= CW'(1)) begin
          w_cnt_nxt    = '0;
          w_tx_req_nxt = 1'b1;
          w_state_nxt  = S_TX;
        end else begin
          w_cnt_nxt = r_cnt - CW'(1);
        end
      end
      S_COOLDOWN: begin
        w_last_nxt  = r_win;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // State and output registers; address/payload captured only on the grant edge.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state   <= S_IDLE;
      r_grant   <= '0;
      r_ack     <= '0;
      r_fail    <= '0;
      r_tx_req  <= 1'b0;
      r_tx_addr <= '0;
      r_tx_data <= '0;
      r_retry   <= '0;
      r_cnt     <= '0;
      r_win     <= '0;
      r_last    <= IW'(NUM_REQ - 1);
    end else begin
      r_state  <= w_state_nxt;
      r_grant  <= w_grant_nxt;
      r_ack    <= w_ack_nxt;
      r_fail   <= w_fail_nxt;
      r_tx_req <= w_tx_req_nxt;
      r_retry  <= w_retry_nxt;
      r_cnt    <= w_cnt_nxt;
      r_win    <= w_win_nxt;
      r_last   <= w_last_nxt;
      if (w_load) begin
        r_tx_addr <= w_rr_addr;
        r_tx_data <= w_rr_data;
      end
    end
  end

  assign o_grant   = r_grant;
  assign o_ack     = r_ack;
  assign o_fail    = r_fail;
  assign o_tx_req  = r_tx_req;
  assign o_tx_addr = r_tx_addr;
  assign o_tx_data = r_tx_data;

endmodule

// File: tb/tb_ulpb_tx_sched.sv
// Testbench for ulpb_tx_sched: directed scenarios plus randomized
// transactions scored against a transaction-level reference model.
module tb_ulpb_tx_sched;

  localparam int NR = 4;
  localparam int AW = 8;
  localparam int DW = 32;
  localparam int MR = 3;
  localparam int BC = 4;
  localparam int OW = 3*NR + 1 + AW + DW;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [NR-1:0]     req;
  logic [NR*AW-1:0]  req_addr;
  logic [NR*DW-1:0]  req_data;
  logic [NR-1:0]     grant, ack, fail;
  logic              tx_req;
  logic [AW-1:0]     tx_addr;
  logic [DW-1:0]     tx_data;
  logic              tx_done, tx_acked, tx_lost;

  int n_pass = 0;
  int n_tot  = 0;

  // Reference model state: previous winner and the message currently latched.
  int           mdl_last = NR - 1;
  logic [AW-1:0] e_addr = '0;
  logic [DW-1:0] e_data = '0;

  logic [OW-1:0] obs, exp_v;
  assign obs = {grant, ack, fail, tx_req, tx_addr, tx_data};

  ulpb_tx_sched #(
    .NUM_REQ(NR), .ADDR_WIDTH(AW), .DATA_WIDTH(DW),
    .MAX_RETRY(MR), .BACKOFF_CYC(BC)
  ) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_req(req), .i_req_addr(req_addr), .i_req_data(req_data),
    .o_grant(grant), .o_ack(ack), .o_fail(fail),
    .o_tx_req(tx_req), .o_tx_addr(tx_addr), .o_tx_data(tx_data),
    .i_tx_done(tx_done), .i_tx_acked(tx_acked), .i_tx_lost(tx_lost)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, passed %0d of %0d", n_pass, n_tot);
    $fatal(1, "watchdog");
  end

  // Model: first requester after the last winner, wrapping modulo NR.
  function automatic int pick(input logic [NR-1:0] r);
    logic [NR-1:0] s;
    for (int k = 1; k <= NR; k++) begin
      s = r >> ((mdl_last + k) % NR);
      if (s[0]) return (mdl_last + k) % NR;
    end
    return -1;
  endfunction

  function automatic logic [OW-1:0] expv(input logic [NR-1:0] g, input logic [NR-1:0] a,
                                         input logic [NR-1:0] f, input logic t,
                                         input logic [AW-1:0] ad, input logic [DW-1:0] d);
    return {g, a, f, t, ad, d};
  endfunction

  task automatic rand_inputs();
    req_addr = $urandom;
    req_data = {$urandom, $urandom, $urandom, $urandom};
  endtask

  task automatic scramble();
    req      = NR'($urandom);
    rand_inputs();
    tx_done  = 1'b0;
    tx_lost  = 1'b0;
    tx_acked = 1'($urandom);
  endtask

  task automatic latch_expect(input int w);
    e_addr = AW'(req_addr >> (w*AW));
    e_data = DW'(req_data >> (w*DW));
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    exp_v = '0;
    n_tot++; if (obs !== exp_v) $display("FAIL rst_state: got %h want %h", obs, exp_v); else n_pass++;
    req = 4'hF;
    rand_inputs();
    @(negedge clk);
    n_tot++; if (obs !== exp_v) $display("FAIL rst_hold_req: got %h want %h", obs, exp_v); else n_pass++;
    req = '0;
    rst_n = 1'b1;
    @(negedge clk);
    n_tot++; if (obs !== exp_v) $display("FAIL rst_idle: got %h want %h", obs, exp_v); else n_pass++;
    mdl_last = NR - 1;
  endtask

  task automatic test_round_robin();
    int seq [5] = '{0, 1, 2, 3, 0};
    logic [NR-1:0] g;
    req = 4'hF;
    for (int n = 0; n < 5; n++) begin
      rand_inputs();
      latch_expect(seq[n]);
      g = NR'(1) << seq[n];
      @(negedge clk);
      exp_v = expv(g, '0, '0, 1'b1, e_addr, e_data);
      n_tot++; if (obs !== exp_v) $display("FAIL rr_grant%0d: got %h want %h", n, obs, exp_v); else n_pass++;
      tx_done = 1'b1; tx_acked = 1'b1;
      @(negedge clk);
      tx_done = 1'b0;
      exp_v = expv('0, g, '0, 1'b0, e_addr, e_data);
      n_tot++; if (obs !== exp_v) $display("FAIL rr_ack%0d: got %h want %h", n, obs, exp_v); else n_pass++;
      if (n == 4) req = '0;
      @(negedge clk);
      exp_v = expv('0, '0, '0, 1'b0, e_addr, e_data);
      n_tot++; if (obs !== exp_v) $display("FAIL rr_idle%0d: got %h want %h", n, obs, exp_v); else n_pass++;
      mdl_last = seq[n];
    end
  endtask

  task automatic test_basic();
    rand_inputs();
    req_addr[7:0]  = 8'h12;
    req_data[31:0] = 32'hDEADBEEF;
    req = 4'b0001;
    e_addr = 8'h12;
    e_data = 32'hDEADBEEF;
    @(negedge clk);
    exp_v = expv(4'b0001, '0, '0, 1'b1, e_addr, e_data);
    n_tot++; if (obs !== exp_v) $display("FAIL basic_grant: got %h want %h", obs, exp_v); else n_pass++;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      n_tot++; if (obs !== exp_v) $display("FAIL basic_tx%0d: got %h want %h", c, obs, exp_v); else n_pass++;
    end
    tx_done = 1'b1; tx_acked = 1'b1; req = '0;
    @(negedge clk);
    tx_done = 1'b0;
    exp_v = expv('0, 4'b0001, '0, 1'b0, e_addr, e_data);
    n_tot++; if (obs !== exp_v) $display("FAIL basic_ack: got %h want %h", obs, exp_v); else n_pass++;
    exp_v = expv('0, '0, '0, 1'b0, e_addr, e_data);
    repeat (2) begin
      @(negedge clk);
      n_tot++; if (obs !== exp_v) $display("FAIL basic_idle: got %h want %h", obs, exp_v); else n_pass++;
    end
    mdl_last = 0;
  endtask

  // Reset during backoff, then a full retry exhaustion from a fresh retry count.
  task automatic test_reset_mid();
    req = 4'b0100;
    rand_inputs();
    latch_expect(2);
    @(negedge clk);
    exp_v = expv(4'b0100, '0, '0, 1'b1, e_addr, e_data);
    n_tot++; if (obs !== exp_v) $display("FAIL rm_grant: got %h want %h", obs, exp_v); else n_pass++;
    tx_lost = 1'b1;
    @(negedge clk);
    tx_lost = 1'b0;
    exp_v = expv(4'b0100, '0, '0, 1'b0, e_addr, e_data);
    n_tot++; if (obs !== exp_v) $display("FAIL rm_backoff: got %h want %h", obs, exp_v); else n_pass++;
    #2 rst_n = 1'b0;
    #1;
    exp_v = '0;
    n_tot++; if (obs !== exp_v) $display("FAIL rm_async_rst: got %h want %h", obs, exp_v); else n_pass++;
    @(negedge clk);
    n_tot++; if (obs !== exp_v) $display("FAIL rm_in_rst: got %h want %h", obs, exp_v); else n_pass++;
    rst_n = 1'b1;
    mdl_last = NR - 1;
    rand_inputs();
    latch_expect(2);
    @(negedge clk);
    exp_v = expv(4'b0100, '0, '0, 1'b1, e_addr, e_data);
    n_tot++; if (obs !== exp_v) $display("FAIL rm_regrant: got %h want %h", obs, exp_v); else n_pass++;
    for (int a = 0; a <= MR; a++) begin
      tx_lost = 1'b1;
      @(negedge clk);
      tx_lost = 1'b0;
      if (a < MR) begin
        exp_v = expv(4'b0100, '0, '0, 1'b0, e_addr, e_data);
        for (int b = 0; b < BC; b++) begin
          if (b > 0) @(negedge clk);
          n_tot++; if (obs !== exp_v) $display("FAIL rm_gap%0d_%0d: got %h want %h", a, b, obs, exp_v); else n_pass++;
        end
        @(negedge clk);
        exp_v = expv(4'b0100, '0, '0, 1'b1, e_addr, e_data);
        n_tot++; if (obs !== exp_v) $display("FAIL rm_retx%0d: got %h want %h", a, obs, exp_v); else n_pass++;
      end else begin
        req = '0;
        exp_v = expv('0, '0, 4'b0100, 1'b0, e_addr, e_data);
        n_tot++; if (obs !== exp_v) $display("FAIL rm_fail: got %h want %h", obs, exp_v); else n_pass++;
      end
    end
    @(negedge clk);
    exp_v = expv('0, '0, '0, 1'b0, e_addr, e_data);
    n_tot++; if (obs !== exp_v) $display("FAIL rm_idle: got %h want %h", obs, exp_v); else n_pass++;
    mdl_last = 2;
  endtask

  // Random messages: random loss counts, ignored noise, inputs scrambled after grant.
  task automatic test_random(input int n);
    logic [NR-1:0] rq, eg;
    int  w, losses, hold;
    bit  ok;
    for (int t = 0; t < n; t++) begin
      rq = NR'($urandom_range(1, (1 << NR) - 1));
      req = rq;
      rand_inputs();
      tx_done = 1'b0; tx_lost = 1'b0;
      w  = pick(rq);
      eg = NR'(1) << w;
      latch_expect(w);
      @(negedge clk);
      exp_v = expv(eg, '0, '0, 1'b1, e_addr, e_data);
      n_tot++; if (obs !== exp_v) $display("FAIL rnd_grant t%0d: got %h want %h", t, obs, exp_v); else n_pass++;
      losses = $urandom_range(0, MR + 1);
      ok = 1'($urandom);
      for (int a = 0; a <= MR; a++) begin
        hold = $urandom_range(0, 2);
        repeat (hold) begin
          scramble();
          @(negedge clk);
          exp_v = expv(eg, '0, '0, 1'b1, e_addr, e_data);
          n_tot++; if (obs !== exp_v) $display("FAIL rnd_tx t%0d: got %h want %h", t, obs, exp_v); else n_pass++;
        end
        scramble();
        if (a < losses) begin
          tx_lost = 1'b1;
          @(negedge clk);
          if (a < MR) begin
            exp_v = expv(eg, '0, '0, 1'b0, e_addr, e_data);
            for (int b = 0; b < BC; b++) begin
              if (b > 0) @(negedge clk);
              n_tot++; if (obs !== exp_v) $display("FAIL rnd_gap t%0d: got %h want %h", t, obs, exp_v); else n_pass++;
              tx_done  = 1'($urandom);
              tx_lost  = 1'($urandom);
              tx_acked = 1'($urandom);
            end
            scramble();
            @(negedge clk);
            exp_v = expv(eg, '0, '0, 1'b1, e_addr, e_data);
            n_tot++; if (obs !== exp_v) $display("FAIL rnd_retx t%0d: got %h want %h", t, obs, exp_v); else n_pass++;
          end else begin
            exp_v = expv('0, '0, eg, 1'b0, e_addr, e_data);
            n_tot++; if (obs !== exp_v) $display("FAIL rnd_maxfail t%0d: got %h want %h", t, obs, exp_v); else n_pass++;
            break;
          end
        end else begin
          tx_done  = 1'b1;
          tx_acked = ok;
          tx_lost  = 1'($urandom);
          @(negedge clk);
          exp_v = expv('0, ok ? eg : '0, ok ? '0 : eg, 1'b0, e_addr, e_data);
          n_tot++; if (obs !== exp_v) $display("FAIL rnd_done t%0d: got %h want %h", t, obs, exp_v); else n_pass++;
          break;
        end
      end
      scramble();
      req     = NR'($urandom_range(1, (1 << NR) - 1));
      tx_done = 1'($urandom);
      tx_lost = 1'($urandom);
      @(negedge clk);
      exp_v = expv('0, '0, '0, 1'b0, e_addr, e_data);
      n_tot++; if (obs !== exp_v) $display("FAIL rnd_cooldown t%0d: got %h want %h", t, obs, exp_v); else n_pass++;
      mdl_last = w;
    end
    req = '0; tx_done = 1'b0; tx_lost = 1'b0;
  endtask

  initial begin
    req = '0; req_addr = '0; req_data = '0;
    tx_done = 1'b0; tx_acked = 1'b0; tx_lost = 1'b0;
    test_reset();
    test_round_robin();
    test_basic();
    test_reset_mid();
    test_random(80);
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
